mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (loads/stores) of the 5-stage RV64 pipeline. It runs one outstanding transaction at a time, holds each requester stalled until its access completes, and drops fetch responses killed by a control-hazard flush. Its stall outputs are ORed into the hazard unit's StallF/StallD/stall-M paths by the core top level.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch and data requesters, one transaction in flight.
// Flushed fetches are withdrawn before grant or have their response silently dropped.
module mem_port_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int MAX_DSTREAK = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                IReqF,
    input  logic [ADDR_W-1:0]   IAddrF,
    input  logic                FlushF,
    output logic                IReadyF,
    output logic [DATA_W-1:0]   IRdataF,
    input  logic                DReqM,
    input  logic                DWeM,
    input  logic [ADDR_W-1:0]   DAddrM,
    input  logic [DATA_W-1:0]   DWdataM,
    input  logic [DATA_W/8-1:0] DStrbM,
    output logic                DReadyM,
    output logic [DATA_W-1:0]   DRdataM,
    output logic                StallIF,
    output logic                StallMem,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_strb,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    // state | meaning
    // IDLE  | no transaction; arbitrate incoming requests
    // ISSUE | mem_req high with latched payload until mem_gnt
    // WAIT  | granted; waiting for mem_rvalid
    // DONE  | one-cycle ready pulse to the owning requester
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam int STRB_W = DATA_W / 8;
    localparam int SW     = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] DS_MAX = SW'(MAX_DSTREAK);

    state_t              state_q;
    logic                owner_data_q;
    logic                drop_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic [SW-1:0]       dstreak_q;
    logic [SW-1:0]       dstreak_d;
    logic                grant_data_d;
    logic [DATA_W-1:0]   irdata_q;
    logic [DATA_W-1:0]   drdata_q;
    logic                flush_own;

    // Data wins by default; fetch wins once data has been favoured MAX_DSTREAK times in a row.
    always_comb begin
        grant_data_d = DReqM && !(IReqF && dstreak_q == DS_MAX);
        dstreak_d    = dstreak_q;
        if (grant_data_d) begin
            if (IReqF && dstreak_q != DS_MAX) begin
                dstreak_d = dstreak_q + 1'b1;
            end
        end else if (IReqF) begin
            dstreak_d = '0;
        end
    end

    assign flush_own = FlushF && !owner_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_data_q <= 1'b0;
            drop_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            strb_q       <= '0;
            dstreak_q    <= '0;
            irdata_q     <= '0;
            drdata_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (DReqM || IReqF) begin
                        owner_data_q <= grant_data_d;
                        we_q         <= grant_data_d && DWeM;
                        addr_q       <= grant_data_d ? DAddrM : IAddrF;
                        wdata_q      <= grant_data_d ? DWdataM : '0;
                        strb_q       <= grant_data_d ? DStrbM : '0;
                        dstreak_q    <= dstreak_d;
                        drop_q       <= 1'b0;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A grant in the same cycle as the flush commits the access; drop its response instead.
                    if (mem_gnt) begin
                        drop_q  <= flush_own;
                        state_q <= WAIT;
                    end else if (flush_own) begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        drop_q <= 1'b0;
                        if (drop_q || flush_own) begin
                            state_q <= IDLE;
                        end else begin
                            if (!we_q) begin
                                if (owner_data_q) drdata_q <= mem_rdata;
                                else              irdata_q <= mem_rdata;
                            end
                            state_q <= DONE;
                        end
                    end else if (flush_own) begin
                        drop_q <= 1'b1;
                    end
                end
                DONE: begin
                    drop_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = (state_q == ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_strb  = strb_q;

    assign IReadyF  = (state_q == DONE) && !owner_data_q && !drop_q;
    assign DReadyM  = (state_q == DONE) && owner_data_q;
    assign IRdataF  = irdata_q;
    assign DRdataM  = drdata_q;
    assign StallIF  = IReqF && !IReadyF;
    assign StallMem = DReqM && !DReadyM;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: per-requester expected-data queues popped on ready pulses,
// with a behavioural memory that can be switched off for hand-driven gnt/rvalid sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        IReqF, FlushF, DReqM, DWeM;
    logic [63:0] IAddrF, DAddrM, DWdataM;
    logic [7:0]  DStrbM;
    logic        IReadyF, DReadyM, StallIF, StallMem;
    logic [63:0] IRdataF, DRdataM;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_strb;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_DSTREAK(3)) dut (
        .clk(clk), .rst(rst),
        .IReqF(IReqF), .IAddrF(IAddrF), .FlushF(FlushF),
        .IReadyF(IReadyF), .IRdataF(IRdataF),
        .DReqM(DReqM), .DWeM(DWeM), .DAddrM(DAddrM), .DWdataM(DWdataM), .DStrbM(DStrbM),
        .DReadyM(DReadyM), .DRdataM(DRdataM),
        .StallIF(StallIF), .StallMem(StallMem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_strb(mem_strb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rdata_for(input logic [63:0] a);
        if (a == 64'h1000) return 64'hDEADBEEF_CAFEF00D;
        return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
    endfunction

    logic [63:0] exp_i[$];
    logic [63:0] exp_d[$];
    byte         order_q[$];

    // Scoreboard: every ready pulse must match the oldest expectation of its requester.
    always @(negedge clk) begin
        if (IReadyF || DReadyM) chk("ready_exclusive", {63'b0, IReadyF & DReadyM}, 64'd0);
        if (IReadyF) begin
            order_q.push_back("I");
            if (exp_i.size() == 0) chk("iready_unexpected", {63'b0, IReadyF}, 64'd0);
            else                   chk("irdata", IRdataF, exp_i.pop_front());
        end
        if (DReadyM) begin
            order_q.push_back("D");
            if (exp_d.size() == 0) chk("dready_unexpected", {63'b0, DReadyM}, 64'd0);
            else                   chk("drdata", DRdataM, exp_d.pop_front());
        end
    end

    // Behavioural memory: grant after gnt_wait cycles of mem_req, rvalid rv_wait cycles after grant.
    bit          mem_auto = 1'b1;
    int          gnt_wait = 0;
    int          rv_wait  = 0;
    int          mm_phase = 0;
    int          mm_cnt   = 0;
    int          n_txn    = 0;
    logic        mm_last_we;
    logic [7:0]  mm_last_strb;
    logic [63:0] mm_last_wdata;
    logic [63:0] mm_rd;

    initial begin
        forever begin
            @(negedge clk);
            if (!mem_auto) begin
                mm_phase = 0;
            end else begin
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b0;
                if (mm_phase == 2) begin
                    if (mm_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = mm_rd;
                        mm_phase   = 0;
                    end else mm_cnt--;
                end else begin
                    if (mm_phase == 0 && mem_req) begin
                        mm_phase = 1;
                        mm_cnt   = gnt_wait;
                    end
                    if (mm_phase == 1) begin
                        if (!mem_req) mm_phase = 0;
                        else if (mm_cnt == 0) begin
                            mem_gnt       = 1'b1;
                            mm_rd         = mem_we ? 64'hBAD0_BAD0_BAD0_BAD0 : rdata_for(mem_addr);
                            mm_last_we    = mem_we;
                            mm_last_strb  = mem_strb;
                            mm_last_wdata = mem_wdata;
                            n_txn++;
                            mm_phase = 2;
                            mm_cnt   = rv_wait;
                        end else mm_cnt--;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    logic [63:0] last_iload, last_dload;
    string       exp_order;
    int          done_cnt;
    bit          seen;

    initial begin
        rst = 1'b1; IReqF = 0; FlushF = 0; DReqM = 0; DWeM = 0;
        IAddrF = '0; DAddrM = '0; DWdataM = '0; DStrbM = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", {63'b0, mem_req}, 64'd0);
        chk("rst_iready",  {63'b0, IReadyF}, 64'd0);
        chk("rst_dready",  {63'b0, DReadyM}, 64'd0);
        chk("rst_irdata",  IRdataF, 64'd0);
        chk("rst_drdata",  DRdataM, 64'd0);

        // Both requesters held from reset release: three data grants then one fetch, twice.
        rv_wait = 1;
        IReqF = 1; IAddrF = 64'h8000; DReqM = 1; DWeM = 0; DAddrM = 64'h9000;
        repeat (2) exp_i.push_back(rdata_for(64'h8000));
        repeat (6) exp_d.push_back(rdata_for(64'h9000));
        last_iload = rdata_for(64'h8000);
        last_dload = rdata_for(64'h9000);
        rst = 0;
        done_cnt = 0;
        for (int c = 0; c < 200 && done_cnt < 8; c++) begin
            @(negedge clk); #1;
            if (IReadyF || DReadyM) done_cnt++;
            if (done_cnt == 8) begin IReqF = 0; DReqM = 0; end
        end
        IReqF = 0; DReqM = 0;
        chk("arb_completions", 64'(done_cnt), 64'd8);
        repeat (3) @(negedge clk);
        exp_order = "DDDIDDDI";
        chk("arb_order_len", 64'(order_q.size()), 64'd8);
        for (int k = 0; k < 8 && k < order_q.size(); k++)
            chk($sformatf("arb_order[%0d]", k), 64'(order_q[k]), 64'(exp_order[k]));

        // Single load, immediate grant: 3-cycle latency, stall through N+2.
        rv_wait = 0;
        @(negedge clk);
        DReqM = 1; DWeM = 0; DAddrM = 64'h1000;
        exp_d.push_back(64'hDEADBEEF_CAFEF00D);
        last_dload = 64'hDEADBEEF_CAFEF00D;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("ld_stall[%0d]", k), {63'b0, StallMem}, {63'b0, k < 3});
            chk($sformatf("ld_ready[%0d]", k), {63'b0, DReadyM}, {63'b0, k == 3});
            chk($sformatf("ld_mem_req[%0d]", k), {63'b0, mem_req}, {63'b0, k == 1});
        end
        DReqM = 0;
        repeat (2) @(negedge clk);

        // Store: payload stable while waiting for grant, load data register untouched.
        gnt_wait = 2;
        DReqM = 1; DWeM = 1; DAddrM = 64'h4000; DWdataM = 64'h11223344; DStrbM = 8'h0F;
        exp_d.push_back(last_dload);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); #1;
            if (mem_req) begin
                chk("st_mem_we",    {63'b0, mem_we}, 64'd1);
                chk("st_mem_strb",  {56'b0, mem_strb}, 64'h0F);
                chk("st_mem_wdata", mem_wdata, 64'h11223344);
            end
            if (DReadyM) begin seen = 1; DReqM = 0; DWeM = 0; end
        end
        chk("st_done", {63'b0, seen}, 64'd1);
        chk("st_mm_we", {63'b0, mm_last_we}, 64'd1);
        chk("st_mm_strb", {56'b0, mm_last_strb}, 64'h0F);
        gnt_wait = 0;
        repeat (2) @(negedge clk);

        // Fetch flushed in ISSUE before any grant: withdrawn, never completes.
        mem_auto = 0; mem_gnt = 0; mem_rvalid = 0;
        IReqF = 1; IAddrF = 64'h2000;
        @(negedge clk); #1;
        chk("fl_issue_req", {63'b0, mem_req}, 64'd1);
        chk("fl_issue_addr", mem_addr, 64'h2000);
        @(negedge clk); #1;
        chk("fl_issue_req2", {63'b0, mem_req}, 64'd1);
        FlushF = 1; IReqF = 0;
        @(negedge clk); FlushF = 0; #1;
        chk("fl_withdrawn", {63'b0, mem_req}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("fl_idle_req", {63'b0, mem_req}, 64'd0);
            chk("fl_no_iready", {63'b0, IReadyF}, 64'd0);
        end

        // Fetch flushed in WAIT: response dropped, next request accepted straight away.
        IReqF = 1; IAddrF = 64'h3000;
        @(negedge clk); #1;
        chk("fw_issue_req", {63'b0, mem_req}, 64'd1);
        mem_gnt = 1;
        @(negedge clk); mem_gnt = 0; FlushF = 1; IReqF = 0;
        @(negedge clk); FlushF = 0;
        @(negedge clk); mem_rvalid = 1; mem_rdata = 64'h13;
        @(negedge clk); mem_rvalid = 0; #1;
        chk("fw_irdata_kept", IRdataF, last_iload);
        chk("fw_no_iready", {63'b0, IReadyF}, 64'd0);
        IReqF = 1; IAddrF = 64'h3100; mem_auto = 1;
        exp_i.push_back(rdata_for(64'h3100));
        @(negedge clk); #1;
        chk("fw_next_req", {63'b0, mem_req}, 64'd1);
        chk("fw_next_addr", mem_addr, 64'h3100);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); #1;
            if (IReadyF) begin seen = 1; IReqF = 0; end
        end
        chk("fw_next_done", {63'b0, seen}, 64'd1);
        repeat (2) @(negedge clk);

        // Reset during WAIT; the late rvalid must be ignored.
        mem_auto = 0; mem_gnt = 0; mem_rvalid = 0;
        DReqM = 1; DWeM = 0; DAddrM = 64'h5000;
        @(negedge clk); mem_gnt = 1;
        @(negedge clk); mem_gnt = 0; rst = 1; DReqM = 0;
        @(negedge clk); rst = 0; #1;
        chk("rw_mem_req", {63'b0, mem_req}, 64'd0);
        chk("rw_dready", {63'b0, DReadyM}, 64'd0);
        chk("rw_irdata", IRdataF, 64'd0);
        chk("rw_drdata", DRdataM, 64'd0);
        chk("rw_stall", {62'b0, StallIF, StallMem}, 64'd0);
        mem_rvalid = 1; mem_rdata = 64'hBAD;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); mem_rvalid = 0; #1;
            chk("rw_late_dready", {63'b0, DReadyM}, 64'd0);
            chk("rw_late_drdata", DRdataM, 64'd0);
            chk("rw_late_req", {63'b0, mem_req}, 64'd0);
        end

        repeat (2) @(negedge clk);
        chk("sb_drain_i", 64'(exp_i.size()), 64'd0);
        chk("sb_drain_d", 64'(exp_d.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
